counter_down_time: RTL and testbench
====================================

# counter_down_time

Two-digit BCD countdown timer with load, enable, prescaler and a held timeout flag cleared by an acknowledge. It complements the progressive 0–9 time counter. The progressive counter measures elapsed time upward. This block is armed with a deadline and counts it down to 00, so the control FSM can enforce time limits. Its `tempo` output feeds the 7-segment display path directly as packed BCD.

## Interface
Parameters:
- `P_PRESCALE`, default 1. Number of enabled `clkt` cycles per countdown step. Legal range is 1–255.

Ports:
- `clkt`  in  1  System clock. All logic runs on the rising edge.
- `R`  in  1  Reset. Synchronous and active-low: sampled on the rising edge of `clkt`, active when 0.
- `load`  in  1  Load strobe. When 1, `load_val` is captured and the timer is armed.
- `load_val`  in  8  Packed BCD start value. Bits [7:4] are tens, bits [3:0] are units.
- `E`  in  1  Count enable. The timer counts only in cycles where `E`=1.
- `ack`  in  1  Timeout acknowledge. Clears `end_time`.
- `tempo`  out  8  Current value as packed BCD. Registered.
- `busy`  out  1  Timer is armed and counting (state RUN). Registered.
- `end_time`  out  1  Timeout flag. Held at 1 until acknowledged. Registered.

## Operation
- Internal state: FSM state (IDLE, RUN, EXPIRED), `tempo`, and a prescaler count `pc` of width ceil(log2(P_PRESCALE)), minimum 1 bit.
- Reset (`R`=0 at an edge) puts the block in:
  - state IDLE
  - `tempo`=8'h00, `pc`=0
  - `busy`=0, `end_time`=0
- Reset overrides every other input.
- Priority order: reset, then `load`, then `ack`, then counting.
- Load, accepted in any state:
  - Each BCD digit of `load_val` above 9 is clamped to 9. For example, 8'hA3 loads as 8'h93.
  - `tempo` takes the clamped value and `pc` is cleared to 0.
  - If the clamped value is nonzero: next state is RUN, `busy`=1, `end_time`=0.
  - If the clamped value is 8'h00: next state is EXPIRED, `end_time`=1, `busy`=0.
- IDLE:
  - `tempo` holds its value.
  - `E` and `ack` are ignored.
- RUN:
  - `E`=0: `tempo` and `pc` hold.
  - `E`=1 and `pc` < P_PRESCALE-1: `pc` increments.
  - `E`=1 and `pc` = P_PRESCALE-1: `pc` is set to 0 and `tempo` steps down by one.
  - BCD decrement rule: if units ≠ 0, units decrements. If units = 0, units becomes 9 and tens decrements.
  - A step never occurs from 00, because RUN is always left on reaching 00.
  - If a step takes `tempo` from 8'h01 to 8'h00: next state is EXPIRED, `end_time`=1, `busy`=0, all on the same edge.
- EXPIRED:
  - `tempo` holds 8'h00 and `E` is ignored.
  - `ack`=1: next state is IDLE and `end_time`=0.
  - `load` together with `ack`: load wins, and `end_time` follows the load rules.
- `ack` in IDLE or RUN has no effect.
- No illegal FSM encodings are reachable. Any unused encoding returns to IDLE at the next edge.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Load latency: `load` sampled at edge k makes `tempo` and `busy` valid after edge k.
- First possible step is at edge k+1. Loading value N (decimal) with `E` held at 1 gives:
  - `end_time` rises at edge k + N·P_PRESCALE;
  - `busy` falls at that same edge.
- Cycles with `E`=0 add delay one for one; the count resumes exactly where it stopped.
- `end_time` stays high for at least one cycle. It falls the edge after `ack` is sampled at 1.
- Reload during RUN restarts the countdown immediately and resets the prescaler phase.
- Reset mid-count takes effect only at an edge. Outputs reach their reset values after that edge.
- Maximum value is 8'h99, i.e. 99 steps. Wrap-around below 00 is impossible by construction.

## Test plan
- Reset, then load 8'h12 with P_PRESCALE=1 and `E`=1 continuously. Required:
  - `tempo` sequence is 12, 11, 10, 09, …, 01, 00;
  - `end_time` rises at edge k+12 and stays high;
  - `busy` falls at that same edge.
- P_PRESCALE=4, load 8'h03, toggle `E` 1/0 every cycle. Required: `end_time` rises 24 cycles after the load edge.
- Load 8'hA0:
  - required: `tempo`=8'h90, state RUN.
  - Then load 8'h00: required `end_time`=1 on the next edge, `busy`=0.
- EXPIRED with `ack` and `load`=8'h05 asserted in the same cycle. Required: `tempo`=8'h05, `busy`=1, `end_time`=0.
- Drive `R`=0 mid-count at `tempo`=8'h07. Required after that edge: `tempo`=8'h00, `busy`=0, `end_time`=0. Then `ack`=1 while IDLE: no change.
- In RUN, hold `E`=0 for 10 cycles. Required: `tempo` and `pc` are frozen. Pulse `ack`: no effect.

Source files
------------

// File: rtl/counter_down_time.sv
// Two-digit BCD countdown timer with load, enable, prescaler and a held timeout flag.
// Armed with a deadline, it counts down to 00 and then raises end_time until it is acknowledged.
module counter_down_time #(
   parameter int P_PRESCALE = 1
) (
   input  logic       clkt,
   input  logic       R,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       E,
   input  logic       ack,
   output logic [7:0] tempo,
   output logic       busy,
   output logic       end_time
);

   // state   | meaning
   // IDLE    | not armed, tempo held, E and ack ignored
   // RUN     | armed, counting down on enabled cycles
   // EXPIRED | reached 00, end_time held until ack or load

   localparam int PW = (P_PRESCALE > 1) ? $clog2(P_PRESCALE) : 1;
   localparam logic [PW-1:0] PC_LAST = PW'(P_PRESCALE - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_EXPIRED = 2'd2
   } state_t;

   state_t        state;
   logic [PW-1:0] pc;
   logic [3:0]    ld_tens;
   logic [3:0]    ld_units;
   logic [7:0]    ld_val;
   logic [7:0]    dec_val;

   // Out-of-range digits are clamped to 9 so tempo is always valid BCD.
   always_comb begin
      ld_tens  = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];
      ld_units = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];
      ld_val   = {ld_tens, ld_units};
      if (tempo[3:0] != 4'd0)
         dec_val = {tempo[7:4], tempo[3:0] - 4'd1};
      else
         dec_val = {tempo[7:4] - 4'd1, 4'd9};
   end

   always_ff @(posedge clkt) begin
      if (!R) begin
         state    <= S_IDLE;
         tempo    <= 8'h00;
         pc       <= '0;
         busy     <= 1'b0;
         end_time <= 1'b0;
      end else if (load) begin
         tempo <= ld_val;
         pc    <= '0;
         if (ld_val != 8'h00) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            end_time <= 1'b0;
         end else begin
            state    <= S_EXPIRED;
            busy     <= 1'b0;
            end_time <= 1'b1;
         end
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_IDLE;
            end
            S_RUN: begin
               if (E) begin
                  if (pc == PC_LAST) begin
                     pc    <= '0;
                     tempo <= dec_val;
                     // Leaving RUN on 01 -> 00 means a step from 00 can never happen.
                     if (tempo == 8'h01) begin
                        state    <= S_EXPIRED;
                        busy     <= 1'b0;
                        end_time <= 1'b1;
                     end
                  end else begin
                     pc <= pc + 1'b1;
                  end
               end
            end
            S_EXPIRED: begin
               if (ack) begin
                  state    <= S_IDLE;
                  end_time <= 1'b0;
               end
            end
            default: begin
               state    <= S_IDLE;
               busy     <= 1'b0;
               end_time <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_down_time.sv
// Directed bench for counter_down_time: a vector table plus hand-written multi-cycle sequences.
// Two instances (prescale 1 and 4) share the same inputs.
module tb_counter_down_time;

   logic       clkt = 1'b0;
   logic       R = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic       E = 1'b0;
   logic       ack = 1'b0;
   logic [7:0] tempo1, tempo4;
   logic       busy1, busy4;
   logic       end1, end4;

   int total = 0;
   int bad = 0;

   always #5 clkt = ~clkt;

   counter_down_time #(.P_PRESCALE(1)) d1 (
      .clkt(clkt), .R(R), .load(load), .load_val(load_val), .E(E), .ack(ack),
      .tempo(tempo1), .busy(busy1), .end_time(end1)
   );

   counter_down_time #(.P_PRESCALE(4)) d4 (
      .clkt(clkt), .R(R), .load(load), .load_val(load_val), .E(E), .ack(ack),
      .tempo(tempo4), .busy(busy4), .end_time(end4)
   );

   typedef struct {
      logic       r;
      logic       ld;
      logic [7:0] lv;
      logic       e;
      logic       ak;
      logic [7:0] t;
      logic       b;
      logic       et;
   } vec_t;

   vec_t vt[22];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic ld, input logic [7:0] lv,
                        input logic e, input logic ak);
      R = r; load = ld; load_val = lv; E = e; ack = ak;
   endtask

   task automatic step();
      @(posedge clkt);
      #1;
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   initial begin
      //            r   ld  lv     e   ak    tempo  busy end
      vt[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h90, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[4]  = '{1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0};
      vt[5]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      vt[9]  = '{1'b1, 1'b1, 8'h3B, 1'b0, 1'b0, 8'h39, 1'b1, 1'b0};
      vt[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h38, 1'b1, 1'b0};
      vt[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h38, 1'b1, 1'b0};
      vt[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h37, 1'b1, 1'b0};
      vt[13] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0};
      vt[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h98, 1'b1, 1'b0};
      vt[15] = '{1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0};
      vt[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 1'b1, 1'b0};
      vt[17] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
      vt[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[19] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
      vt[20] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      vt[21] = '{1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0};

      #2;
      for (int i = 0; i < 22; i++) begin
         drive(vt[i].r, vt[i].ld, vt[i].lv, vt[i].e, vt[i].ak);
         step();
         chk($sformatf("vec%0d tempo", i), tempo1, vt[i].t);
         chk($sformatf("vec%0d busy", i), {7'd0, busy1}, {7'd0, vt[i].b});
         chk($sformatf("vec%0d end_time", i), {7'd0, end1}, {7'd0, vt[i].et});
      end

      // Full countdown from 12 at prescale 1.
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b1, 8'h12, 1'b1, 1'b0);
      step();
      chk("cd12 load tempo", tempo1, 8'h12);
      chk("cd12 load busy", {7'd0, busy1}, 8'h01);
      load = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         step();
         chk($sformatf("cd12 step%0d tempo", i), tempo1, (i <= 12) ? to_bcd(12 - i) : 8'h00);
         chk($sformatf("cd12 step%0d busy", i), {7'd0, busy1}, (i < 12) ? 8'h01 : 8'h00);
         chk($sformatf("cd12 step%0d end_time", i), {7'd0, end1}, (i >= 12) ? 8'h01 : 8'h00);
      end

      // Prescale 4, load 03, E toggling starting low after the load edge.
      drive(1'b1, 1'b1, 8'h03, 1'b1, 1'b0);
      step();
      chk("ps4 load tempo", tempo4, 8'h03);
      load = 1'b0;
      for (int i = 1; i <= 24; i++) begin
         E = (i % 2 == 0);
         step();
         chk($sformatf("ps4 edge%0d end_time", i), {7'd0, end4}, (i == 24) ? 8'h01 : 8'h00);
         chk($sformatf("ps4 edge%0d busy", i), {7'd0, busy4}, (i < 24) ? 8'h01 : 8'h00);
      end
      chk("ps4 final tempo", tempo4, 8'h00);

      // Freeze: prescaler phase must survive 10 disabled cycles with an ack pulse.
      drive(1'b1, 1'b1, 8'h05, 1'b1, 1'b0);
      step();
      load = 1'b0;
      step();
      step();
      E = 1'b0;
      for (int i = 0; i < 10; i++) begin
         ack = (i == 4);
         step();
         chk($sformatf("freeze%0d tempo", i), tempo4, 8'h05);
         chk($sformatf("freeze%0d busy", i), {7'd0, busy4}, 8'h01);
         chk($sformatf("freeze%0d end_time", i), {7'd0, end4}, 8'h00);
      end
      ack = 1'b0;
      E = 1'b1;
      step();
      chk("resume1 tempo", tempo4, 8'h05);
      step();
      chk("resume2 tempo", tempo4, 8'h04);

      // Reset mid-count at 07, then ack in IDLE.
      drive(1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
      step();
      load = 1'b0;
      step();
      step();
      step();
      chk("pre-reset tempo", tempo1, 8'h07);
      R = 1'b0;
      step();
      chk("reset tempo", tempo1, 8'h00);
      chk("reset busy", {7'd0, busy1}, 8'h00);
      chk("reset end_time", {7'd0, end1}, 8'h00);
      R = 1'b1;
      ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("idle ack%0d tempo", i), tempo1, 8'h00);
         chk($sformatf("idle ack%0d busy", i), {7'd0, busy1}, 8'h00);
         chk($sformatf("idle ack%0d end_time", i), {7'd0, end1}, 8'h00);
      end
      ack = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
